sqrt_seq_ctrl: RTL

// - Sequential controller and iterative engine for the fixed-point square root.
// - Accepts an unsigned integer sample over a valid/ready handshake.
// - Resolves one result bit per clock, MSB first, using trial-square compare.
// - Returns out = floor(sqrt(in * 2^(2*FRAC_W))), i.e. sqrt(in) in Q(IN_W).(FRAC_W).
// - Replaces the wide combinational root in the baggage-drop datapath with a bounded-latency

---
 rtl/sqrt_seq_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/sqrt_seq_ctrl.sv
// Iterative fixed-point square root: one result bit per clock, MSB first.
// out_data = floor(sqrt(in_data * 2^(2*FRAC_W))), valid/ready on both sides.
module sqrt_seq_ctrl #(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned OUT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned RW   = IN_W + 2 * FRAC_W;
    localparam int unsigned ITER = (RW + 1) / 2;
    localparam int unsigned PW   = 2 * ITER;
    localparam int unsigned KW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     r_q, r_d;
    logic [ITER-1:0]   y_q, y_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ITER-1:0]   res_q, res_d;
    logic [ITER-1:0]   trial;
    logic [PW-1:0]     trial_sq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            y_q     <= y_d;
            k_q     <= k_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        // Full-width square: a trial root of ITER bits never overflows PW bits.
        trial    = y_q | (ITER'(1) << k_q);
        trial_sq = PW'(trial) * PW'(trial);
        state_d  = state_q;
        r_d      = r_q;
        y_d      = y_q;
        k_d      = k_q;
        res_d    = res_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    r_d     = PW'({in_data, {(2 * FRAC_W){1'b0}}});
                    y_d     = '0;
                    k_d     = KW'(ITER - 1);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (trial_sq <= r_q) begin
                    y_d = trial;
                end
                if (k_q == '0) begin
                    res_d   = y_d;
                    state_d = StDone;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = OUT_W'(res_q);

endmodule
